ws2812b_frame_ctrl: RTL and testbench

Frame sequencer for the WS2812B bit encoder. It holds a host-writable pixel buffer and applies a global brightness scale and RGB→GRB reordering. It streams one frame of pixels into the encoder over its valid/ready/latch handshake and asserts latch on the last pixel. It then waits out the encoder's reset pulse before reporting completion. It sits between the peripheral register interface and the encoder instance.

---
 rtl/ws2812b_pkg.sv | 21 ++
 rtl/ws2812b_pixbuf.sv | 36 +++
 rtl/ws2812b_frame_ctrl.sv | 149 ++++++++++++++
 tb/tb_ws2812b_frame_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812b_pkg.sv
// Shared types and helpers for the WS2812B frame sequencer: FSM states,
// pixel width and the RGB-to-GRB wire-order reorder.
package ws2812b_pkg;

    localparam int PIX_W = 24;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SCALE,
        OFFER,
        DRAIN,
        DONE
    } state_e;

    // The LED expects green first on the wire.
    function automatic logic [PIX_W-1:0] rgb_to_grb(input logic [PIX_W-1:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage

// File: rtl/ws2812b_pixbuf.sv
// Pixel buffer: one write port, one synchronous read port with 1-cycle latency.
// Contents are deliberately not reset so a host image survives a controller reset.
module ws2812b_pixbuf
    import ws2812b_pkg::*;
#(
    parameter int NUM_LEDS = 16,
    parameter int ADDR_W   = 8,
    parameter int IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [PIX_W-1:0] rd_data
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(NUM_LEDS);

    logic [PIX_W-1:0] mem_q [NUM_LEDS];
    logic [PIX_W-1:0] rd_data_q;
    logic             wr_ok;

    // Out-of-range addresses are dropped rather than aliased onto low entries.
    assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_addr[IDX_W-1:0]] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ws2812b_frame_ctrl.sv
// Frame sequencer: streams the pixel buffer, brightness-scaled and GRB-ordered,
// into the WS2812B encoder and waits out the encoder reset pulse per frame.
module ws2812b_frame_ctrl
    import ws2812b_pkg::*;
#(
    parameter int NUM_LEDS = 16,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic [ADDR_W:0]   frame_len,
    input  logic [7:0]        bright,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_count,
    output logic [23:0]       px_data,
    output logic              px_valid,
    output logic              px_latch,
    input  logic              px_ready
);

    localparam int              IDX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(NUM_LEDS);

    // (c * (bright+1)) >> 8 keeps full scale exact at bright=255.
    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [8:0] gain);
        return 8'((16'(c) * 16'(gain)) >> 8);
    endfunction

    function automatic logic [PIX_W-1:0] scale_px(input logic [PIX_W-1:0] rgb,
                                                  input logic [7:0] br);
        logic [8:0] gain;
        gain = {1'b0, br} + 9'd1;
        return {scale_ch(rgb[23:16], gain), scale_ch(rgb[15:8], gain), scale_ch(rgb[7:0], gain)};
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [7:0]        bright_q, bright_d;
    logic [PIX_W-1:0]  px_data_q, px_data_d;
    logic              px_latch_q, px_latch_d;
    logic              px_valid_q, px_valid_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic [PIX_W-1:0]  rd_data;

    ws2812b_pixbuf #(
        .NUM_LEDS (NUM_LEDS),
        .ADDR_W   (ADDR_W),
        .IDX_W    (IDX_W)
    ) u_pixbuf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx_q[IDX_W-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            len_q         <= '0;
            bright_q      <= '0;
            px_data_q     <= '0;
            px_latch_q    <= 1'b0;
            px_valid_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            bright_q      <= bright_d;
            px_data_q     <= px_data_d;
            px_latch_q    <= px_latch_d;
            px_valid_q    <= px_valid_d;
            frame_count_q <= frame_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        len_d         = len_q;
        bright_d      = bright_q;
        px_data_d     = px_data_q;
        px_latch_d    = px_latch_q;
        px_valid_d    = px_valid_q;
        frame_count_d = frame_count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
                    bright_d = bright;
                    idx_d    = '0;
                    state_d  = (frame_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                state_d = SCALE;
            end
            SCALE: begin
                px_data_d  = rgb_to_grb(scale_px(rd_data, bright_q));
                px_latch_d = ({1'b0, idx_q} == (len_q - (ADDR_W + 1)'(1)));
                px_valid_d = 1'b1;
                state_d    = OFFER;
            end
            OFFER: begin
                if (px_ready) begin
                    px_valid_d = 1'b0;
                    px_latch_d = 1'b0;
                    if (px_latch_q) begin
                        state_d = DRAIN;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            // Encoder re-raises ready only after its latch/reset pulse.
            DRAIN: begin
                if (px_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                frame_count_d = frame_count_q + 16'd1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign frame_count = frame_count_q;
    assign px_data     = px_data_q;
    assign px_valid    = px_valid_q;
    assign px_latch    = px_latch_q;

endmodule

// File: tb/tb_ws2812b_frame_ctrl.sv
// Directed bench for ws2812b_frame_ctrl: one task per scenario with inline
// checks against hand-computed GRB/scaled pixel values.
module tb_ws2812b_frame_ctrl;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [23:0] wr_data;
    logic [8:0]  frame_len;
    logic [7:0]  bright;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] frame_count;
    logic [23:0] px_data;
    logic        px_valid;
    logic        px_latch;
    logic        px_ready;

    int total = 0;
    int bad   = 0;

    logic [23:0] q_data[$];
    logic        q_latch[$];
    int          done_cnt  = 0;
    int          valid_cnt = 0;

    ws2812b_frame_ctrl #(.NUM_LEDS(16), .ADDR_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_len   (frame_len),
        .bright      (bright),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .frame_count (frame_count),
        .px_data     (px_data),
        .px_valid    (px_valid),
        .px_latch    (px_latch),
        .px_ready    (px_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after posedge; the monitor samples on negedge.
    always @(negedge clk) begin
        if (px_valid && px_ready) begin
            q_data.push_back(px_data);
            q_latch.push_back(px_latch);
        end
        if (done) done_cnt++;
        if (px_valid) valid_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input logic [7:0] a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic start_frame(input logic [8:0] len, input logic [7:0] br);
        frame_len = len;
        bright    = br;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_valid(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (px_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
        total++; if (px_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", px_valid); end
        total++; if (px_latch !== 1'b0) begin bad++; $display("FAIL reset_latch got=%0b exp=0", px_latch); end
        total++; if (px_data !== 24'h0) begin bad++; $display("FAIL reset_data got=%h exp=000000", px_data); end
        total++; if (frame_count !== 16'h0) begin bad++; $display("FAIL reset_count got=%0d exp=0", frame_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        int base, d0;
        bit ok;
        px_ready = 1'b1;
        write_px(8'd0, 24'hFF0000);
        write_px(8'd1, 24'h00FF00);
        write_px(8'd2, 24'h0000FF);
        base = q_data.size();
        d0   = done_cnt;
        start_frame(9'd3, 8'd255);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%0b exp=1", busy); end
        total++; if (px_valid !== 1'b0) begin bad++; $display("FAIL start_valid_t1 got=%0b exp=0", px_valid); end
        tick();
        total++; if (px_valid !== 1'b0) begin bad++; $display("FAIL start_valid_t2 got=%0b exp=0", px_valid); end
        tick();
        total++; if (px_valid !== 1'b1) begin bad++; $display("FAIL start_valid_t3 got=%0b exp=1", px_valid); end
        wait_idle(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout got=busy exp=idle"); end
        total++;
        if (q_data.size() - base != 3) begin
            bad++; $display("FAIL single_count got=%0d exp=3", q_data.size() - base);
        end else begin
            if (q_data[base] !== 24'h00FF00 || q_data[base+1] !== 24'hFF0000 || q_data[base+2] !== 24'h0000FF) begin
                bad++; $display("FAIL single_data got=%h %h %h exp=00ff00 ff0000 0000ff",
                                q_data[base], q_data[base+1], q_data[base+2]);
            end
            total++;
            if (q_latch[base] !== 1'b0 || q_latch[base+1] !== 1'b0 || q_latch[base+2] !== 1'b1) begin
                bad++; $display("FAIL single_latch got=%b%b%b exp=001",
                                q_latch[base], q_latch[base+1], q_latch[base+2]);
            end
        end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL single_done got=%0d exp=1", done_cnt - d0); end
        total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL single_fcount got=%0d exp=1", frame_count); end
    endtask

    task automatic test_brightness();
        int base;
        bit ok;
        write_px(8'd0, 24'h80FF40);
        base = q_data.size();
        start_frame(9'd1, 8'd127);
        wait_idle(50, ok);
        total++; if (!ok) begin bad++; $display("FAIL bright_timeout got=busy exp=idle"); end
        total++;
        if (q_data.size() - base != 1) begin
            bad++; $display("FAIL bright_count got=%0d exp=1", q_data.size() - base);
        end else if (q_data[base] !== 24'h7F4020 || q_latch[base] !== 1'b1) begin
            bad++; $display("FAIL bright_data got=%h latch=%b exp=7f4020 latch=1", q_data[base], q_latch[base]);
        end
        total++; if (frame_count !== 16'd2) begin bad++; $display("FAIL bright_fcount got=%0d exp=2", frame_count); end
    endtask

    task automatic test_stall();
        int  base;
        int  unstable;
        bit  ok;
        write_px(8'd0, 24'h123456);
        px_ready = 1'b0;
        start_frame(9'd1, 8'd255);
        wait_valid(10, ok);
        total++; if (!ok) begin bad++; $display("FAIL stall_valid_timeout got=0 exp=1"); end
        unstable = 0;
        for (int i = 0; i < 50; i++) begin
            if (px_valid !== 1'b1 || px_data !== 24'h341256) unstable++;
            tick();
        end
        total++; if (unstable != 0) begin bad++; $display("FAIL stall_stable got=%0d unstable exp=0", unstable); end
        base = q_data.size();
        px_ready = 1'b1;
        tick();
        px_ready = 1'b0;
        total++; if (px_valid !== 1'b0) begin bad++; $display("FAIL stall_drop got=%0b exp=0", px_valid); end
        tick();
        tick();
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL drain_wait got=%0b exp=1", busy); end
        px_ready = 1'b1;
        wait_idle(20, ok);
        total++; if (!ok) begin bad++; $display("FAIL stall_timeout got=busy exp=idle"); end
        total++; if (q_data.size() - base != 1) begin bad++; $display("FAIL stall_xfers got=%0d exp=1", q_data.size() - base); end
        total++; if (frame_count !== 16'd3) begin bad++; $display("FAIL stall_fcount got=%0d exp=3", frame_count); end
    endtask

    task automatic test_len_zero();
        int d0, v0;
        d0 = done_cnt;
        v0 = valid_cnt;
        start_frame(9'd0, 8'd255);
        total++; if (busy !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL len0_t1 got=busy%0b done%0b exp=busy1 done1", busy, done); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL len0_idle got=%0b exp=0", busy); end
        total++; if (valid_cnt != v0) begin bad++; $display("FAIL len0_novalid got=%0d exp=0", valid_cnt - v0); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL len0_done got=%0d exp=1", done_cnt - d0); end
        total++; if (frame_count !== 16'd4) begin bad++; $display("FAIL len0_fcount got=%0d exp=4", frame_count); end
    endtask

    task automatic test_len_clamp();
        int base, errs, lerrs;
        bit ok;
        logic [7:0] k;
        for (int i = 0; i < 16; i++) begin
            k = 8'(i);
            write_px(k, {k, k + 8'd16, k + 8'd32});
        end
        base = q_data.size();
        start_frame(9'd300, 8'd255);
        wait_idle(300, ok);
        total++; if (!ok) begin bad++; $display("FAIL clamp_timeout got=busy exp=idle"); end
        total++;
        if (q_data.size() - base != 16) begin
            bad++; $display("FAIL clamp_count got=%0d exp=16", q_data.size() - base);
        end else begin
            errs  = 0;
            lerrs = 0;
            for (int i = 0; i < 16; i++) begin
                k = 8'(i);
                if (q_data[base+i] !== {k + 8'd16, k, k + 8'd32}) errs++;
                if (q_latch[base+i] !== (i == 15)) lerrs++;
            end
            total++; if (errs != 0) begin bad++; $display("FAIL clamp_data got=%0d wrong exp=0", errs); end
            total++; if (lerrs != 0) begin bad++; $display("FAIL clamp_latch got=%0d wrong exp=0", lerrs); end
        end
    endtask

    task automatic test_start_busy();
        int base, d0;
        bit ok;
        base = q_data.size();
        d0   = done_cnt;
        start_frame(9'd2, 8'd255);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL busy_timeout got=busy exp=idle"); end
        tick();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_requeued got=%0b exp=0", busy); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL busy_done got=%0d exp=1", done_cnt - d0); end
        total++; if (q_data.size() - base != 2) begin bad++; $display("FAIL busy_xfers got=%0d exp=2", q_data.size() - base); end
    endtask

    task automatic test_mid_frame();
        int base;
        bit ok;
        write_px(8'd0, 24'h112233);
        write_px(8'd1, 24'h445566);
        write_px(8'd2, 24'h778899);
        write_px(8'd3, 24'hAABBCC);
        px_ready = 1'b0;
        base = q_data.size();
        start_frame(9'd5, 8'd255);
        wait_valid(10, ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_valid_timeout got=0 exp=1"); end
        write_px(8'd20, 24'hFFFFFF);
        write_px(8'd2, 24'h010203);
        px_ready = 1'b1;
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_timeout got=busy exp=idle"); end
        total++;
        if (q_data.size() - base != 5) begin
            bad++; $display("FAIL mid_count got=%0d exp=5", q_data.size() - base);
        end else begin
            if (q_data[base] !== 24'h221133 || q_data[base+1] !== 24'h554466 || q_data[base+3] !== 24'hBBAACC) begin
                bad++; $display("FAIL mid_data got=%h %h %h exp=221133 554466 bbaacc",
                                q_data[base], q_data[base+1], q_data[base+3]);
            end
            total++;
            if (q_data[base+2] !== 24'h020103) begin
                bad++; $display("FAIL mid_overwrite got=%h exp=020103", q_data[base+2]);
            end
            total++;
            if (q_data[base+4] !== 24'h140424) begin
                bad++; $display("FAIL mid_oob_write got=%h exp=140424", q_data[base+4]);
            end
        end
    endtask

    task automatic test_rst_mid();
        int base;
        bit ok;
        px_ready = 1'b0;
        start_frame(9'd3, 8'd255);
        wait_valid(10, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_valid_timeout got=0 exp=1"); end
        rst = 1'b1;
        #1;
        total++; if (px_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%0b exp=0", px_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
        total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL rstmid_fcount got=%0d exp=0", frame_count); end
        tick();
        rst = 1'b0;
        tick();
        px_ready = 1'b1;
        base = q_data.size();
        start_frame(9'd3, 8'd255);
        wait_idle(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL rerun_timeout got=busy exp=idle"); end
        total++;
        if (q_data.size() - base != 3) begin
            bad++; $display("FAIL rerun_count got=%0d exp=3", q_data.size() - base);
        end else if (q_data[base] !== 24'h221133 || q_data[base+2] !== 24'h020103 || q_latch[base+2] !== 1'b1) begin
            bad++; $display("FAIL rerun_data got=%h %h exp=221133 020103", q_data[base], q_data[base+2]);
        end
        total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL rerun_fcount got=%0d exp=1", frame_count); end
    endtask

    task automatic test_wrap();
        force dut.frame_count_q = 16'hFFFF;
        tick();
        release dut.frame_count_q;
        tick();
        total++; if (frame_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=ffff", frame_count); end
        start_frame(9'd0, 8'd0);
        tick();
        total++; if (frame_count !== 16'h0000) begin bad++; $display("FAIL wrap_count got=%h exp=0000", frame_count); end
    endtask

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        frame_len = '0;
        bright    = '0;
        start     = 1'b0;
        px_ready  = 1'b0;
        test_reset();
        test_single_frame();
        test_brightness();
        test_stall();
        test_len_zero();
        test_len_clamp();
        test_start_busy();
        test_mid_frame();
        test_rst_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
